// File: rtl/frame_payload_fifo.sv
// First-word-fall-through payload buffer feeding the frame former.
// Head word is read combinationally from the array, so a push is visible the next cycle.
module frame_payload_fifo #(
    parameter  int DEPTH  = 512,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic [63:0]       S_AXIS_tdata,
    input  logic [7:0]        S_AXIS_tkeep,
    input  logic              S_AXIS_tvalid,
    output logic              S_AXIS_tready,
    input  logic              S_AXIS_tlast,
    input  logic [13:0]       Payload_Words,
    input  logic              pop,
    output logic [63:0]       Output_Data,
    output logic              is_empty,
    output logic              is_full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic [15:0]       underflow_cnt,
    output logic [15:0]       burst_cnt
);

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

    logic [63:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   level_q, level_nxt;
    logic              tready_q;
    logic [63:0]       wdata;
    logic              push, pop_eff, pop_uf;

    // Byte lanes with tkeep low are stored as zero.
    for (genvar b = 0; b < 8; b++) begin : g_keep
        assign wdata[8*b +: 8] = S_AXIS_tkeep[b] ? S_AXIS_tdata[8*b +: 8] : 8'h00;
    end

    assign empty   = (level_q == '0);
    assign is_full = (level_q == FULL_LVL);
    assign level   = level_q;
    // A zero threshold never gates; one above DEPTH gates forever.
    assign is_empty = 16'(level_q) < 16'(Payload_Words);

    assign push    = S_AXIS_tvalid && tready_q;
    assign pop_eff = pop && !empty;
    assign pop_uf  = pop && empty;

    assign S_AXIS_tready = tready_q;
    assign Output_Data   = empty ? 64'h0 : mem[rd_ptr];

    always_comb begin
        level_nxt = level_q;
        if (push && !pop_eff)
            level_nxt = level_q + (ADDR_W+1)'(1);
        else if (!push && pop_eff)
            level_nxt = level_q - (ADDR_W+1)'(1);
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level_q       <= '0;
            tready_q      <= 1'b0;
            underflow_cnt <= '0;
            burst_cnt     <= '0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop_eff) rd_ptr <= rd_ptr + ADDR_W'(1);
            level_q  <= level_nxt;
            // Ready follows the registered level only, so pop has no combinational path to it.
            tready_q <= (level_nxt != FULL_LVL);
            if (pop_uf && underflow_cnt != 16'hFFFF)
                underflow_cnt <= underflow_cnt + 16'd1;
            if (push && S_AXIS_tlast)
                burst_cnt <= burst_cnt + 16'd1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: tb/tb_frame_payload_fifo.sv
// Bench for frame_payload_fifo: queue model checked every cycle plus directed literal checks.
module tb_frame_payload_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          ACLK = 0;
    logic          ARESETN;
    logic [63:0]   S_AXIS_tdata;
    logic [7:0]    S_AXIS_tkeep;
    logic          S_AXIS_tvalid;
    logic          S_AXIS_tready;
    logic          S_AXIS_tlast;
    logic [13:0]   Payload_Words;
    logic          pop;
    logic [63:0]   Output_Data;
    logic          is_empty, is_full, empty;
    logic [AW:0]   level;
    logic [15:0]   underflow_cnt, burst_cnt;

    frame_payload_fifo #(.DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tkeep(S_AXIS_tkeep),
        .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
        .S_AXIS_tlast(S_AXIS_tlast), .Payload_Words(Payload_Words), .pop(pop),
        .Output_Data(Output_Data), .is_empty(is_empty), .is_full(is_full),
        .empty(empty), .level(level), .underflow_cnt(underflow_cnt), .burst_cnt(burst_cnt)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words held in a queue, status derived from its size.
    logic [63:0] q[$];
    int          m_uf = 0, m_bc = 0;
    bit          m_rdy = 0;

    function automatic logic [63:0] mask(input logic [63:0] d, input logic [7:0] k);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = k[b] ? d[8*b +: 8] : 8'h00;
        return r;
    endfunction

    always @(posedge ACLK) begin
        if (!ARESETN) begin
            q.delete();
            m_uf  = 0;
            m_bc  = 0;
            m_rdy = 0;
        end else begin
            bit acc;
            acc = S_AXIS_tvalid && m_rdy;
            if (pop && q.size() == 0) begin
                if (m_uf < 16'hFFFF) m_uf++;
            end else if (pop) begin
                void'(q.pop_front());
            end
            if (acc) begin
                q.push_back(mask(S_AXIS_tdata, S_AXIS_tkeep));
                if (S_AXIS_tlast) m_bc = (m_bc + 1) % 65536;
            end
            m_rdy = (q.size() != DEPTH);
        end
    end

    always @(negedge ACLK) begin
        if (chk_en) begin
            check("data",   Output_Data, (q.size() > 0) ? q[0] : 64'h0);
            check("empty",  64'(empty), 64'(q.size() == 0));
            check("full",   64'(is_full), 64'(q.size() == DEPTH));
            check("is_empty", 64'(is_empty), 64'(q.size() < int'(Payload_Words)));
            check("level",  64'(level), 64'(q.size()));
            check("tready", 64'(S_AXIS_tready), 64'(m_rdy));
            check("uf_cnt", 64'(underflow_cnt), 64'(m_uf));
            check("burst",  64'(burst_cnt), 64'(m_bc));
        end
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic push1(input logic [63:0] d);
        S_AXIS_tdata = d; S_AXIS_tkeep = 8'hFF; S_AXIS_tvalid = 1;
        step();
        S_AXIS_tvalid = 0;
    endtask

    logic [63:0] seq [4];

    initial begin
        ARESETN = 0; S_AXIS_tdata = 0; S_AXIS_tkeep = 8'hFF; S_AXIS_tvalid = 0;
        S_AXIS_tlast = 0; Payload_Words = 14'd4; pop = 0;
        step();
        chk_en = 1;
        step(); step();
        check("tready_in_reset", 64'(S_AXIS_tready), 64'h0);
        ARESETN = 1;
        step();
        // Idle after reset
        check("rst_tready", 64'(S_AXIS_tready), 64'h1);
        check("rst_empty",  64'(empty), 64'h1);
        check("rst_is_empty", 64'(is_empty), 64'h1);
        check("rst_data",   Output_Data, 64'h0);
        repeat (20) step();
        check("idle_level", 64'(level), 64'h0);
        check("idle_uf",    64'(underflow_cnt), 64'h0);
        check("idle_burst", 64'(burst_cnt), 64'h0);

        // Frame threshold at 4 words
        seq[0] = 64'h1111111111111111; seq[1] = 64'h2222222222222222;
        seq[2] = 64'h3333333333333333; seq[3] = 64'h4444444444444444;
        for (int i = 0; i < 3; i++) push1(seq[i]);
        check("thr_below", 64'(is_empty), 64'h1);
        check("thr_level3", 64'(level), 64'h3);
        push1(seq[3]);
        check("thr_reached", 64'(is_empty), 64'h0);
        pop = 1;
        for (int i = 0; i < 4; i++) begin
            check("pop_seq", Output_Data, seq[i]);
            step();
        end
        pop = 0;
        check("drained_empty", 64'(empty), 64'h1);
        check("drained_data", Output_Data, 64'h0);

        // Fill to DEPTH, ninth word held until a slot frees
        for (int i = 0; i < 8; i++) push1(64'(100 + i));
        S_AXIS_tdata = 64'd108; S_AXIS_tvalid = 1;
        step();
        check("full_flag",   64'(is_full), 64'h1);
        check("full_tready", 64'(S_AXIS_tready), 64'h0);
        check("full_level",  64'(level), 64'h8);
        pop = 1;
        step();
        pop = 0;
        check("after_pop_tready", 64'(S_AXIS_tready), 64'h1);
        check("after_pop_level",  64'(level), 64'h7);
        check("after_pop_head",   Output_Data, 64'd101);
        step();
        S_AXIS_tvalid = 0;
        check("ninth_level", 64'(level), 64'h8);
        pop = 1;
        repeat (8) step();
        pop = 0;
        check("full_drain", 64'(empty), 64'h1);

        // Simultaneous push/pop at level 3
        for (int i = 0; i < 3; i++) push1(64'(200 + i));
        pop = 1; S_AXIS_tvalid = 1;
        for (int i = 0; i < 10; i++) begin
            S_AXIS_tdata = 64'(300 + i);
            step();
        end
        pop = 0; S_AXIS_tvalid = 0;
        check("pp_level", 64'(level), 64'h3);
        check("pp_head",  Output_Data, 64'd307);
        pop = 1;
        repeat (3) step();
        pop = 0;

        // Underflow
        pop = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("uf_data", Output_Data, 64'h0);
        end
        pop = 0;
        check("uf_cnt5", 64'(underflow_cnt), 64'h5);
        push1(64'hDEAD);
        check("uf_push_vis", Output_Data, 64'hDEAD);
        pop = 1; step(); pop = 0;
        // Push and pop while empty: pop counts as underflow, push stored
        pop = 1; S_AXIS_tdata = 64'hBEEF; S_AXIS_tvalid = 1;
        step();
        pop = 0; S_AXIS_tvalid = 0;
        check("ep_uf6",   64'(underflow_cnt), 64'h6);
        check("ep_level", 64'(level), 64'h1);
        check("ep_data",  Output_Data, 64'hBEEF);
        pop = 1; step(); pop = 0;

        // Threshold corner settings
        Payload_Words = 14'd0;
        step();
        check("pw0_is_empty", 64'(is_empty), 64'h0);
        Payload_Words = 14'd9;
        repeat (8) push1(64'h55);
        check("pw9_is_empty", 64'(is_empty), 64'h1);
        pop = 1; repeat (8) step(); pop = 0;
        Payload_Words = 14'd4;

        // tkeep masking, burst count, reset mid-stream
        S_AXIS_tdata = 64'hAABBCCDD_11223344; S_AXIS_tkeep = 8'h0F; S_AXIS_tvalid = 1;
        step();
        S_AXIS_tvalid = 0; S_AXIS_tkeep = 8'hFF;
        check("keep_mask", Output_Data, 64'h00000000_11223344);
        S_AXIS_tkeep = 8'h0F; S_AXIS_tlast = 1; S_AXIS_tvalid = 1;
        step();
        S_AXIS_tvalid = 0; S_AXIS_tlast = 0; S_AXIS_tkeep = 8'hFF;
        check("burst1", 64'(burst_cnt), 64'h1);
        check("burst_level", 64'(level), 64'h2);
        S_AXIS_tvalid = 1; S_AXIS_tdata = 64'h77;
        ARESETN = 0;
        step();
        S_AXIS_tvalid = 0;
        check("rst_mid_level", 64'(level), 64'h0);
        check("rst_mid_burst", 64'(burst_cnt), 64'h0);
        check("rst_mid_uf",    64'(underflow_cnt), 64'h0);
        check("rst_mid_data",  Output_Data, 64'h0);
        ARESETN = 1;
        step();
        check("rel_tready", 64'(S_AXIS_tready), 64'h1);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
